// File: rtl/fx2_slave_fifo.sv
// fx2_slave_fifo
//   Behavioural model of the FPGA-facing side of a Cypress FX2 in slave-FIFO
//   mode, with a simple host-side port pair standing in for the USB host.
//   FIFO2 carries PC->FPGA bytes (host pushes, FPGA reads over FX2_FD).
//   FIFO4 carries FPGA->PC bytes (FPGA writes over FX2_FD, host pops only
//   committed bytes; commit happens on PKTEND or after PKT_SIZE bytes).
//
// Ports
//   FX2_CLK, FX2_RST_N          clock, async active-low reset
//   FX2_FD[7:0]                 bidirectional data bus
//   FX2_SLRD, FX2_SLWR          read / write strobes (active-low)
//   FX2_PA_2                    SLOE, bus-drive enable (active-low)
//   FX2_PA_5, FX2_PA_4          FIFOADR[1:0]
//   FX2_PA_6                    PKTEND (active-low)
//   FX2_flags[2:0]              {FIFO4 not full, 0, FIFO2 not empty}
//   FX2_PA_7                    FIFO5 not full (constant 1)
//   HOST_WR_*                   push port into FIFO2
//   HOST_RD_*                   pop port out of FIFO4 (committed data)
//   HOST_PKT, HOST_ZLP          one-cycle commit pulses
//   RD_UNDERFLOW, WR_OVERFLOW   sticky error flags
//
// Host handshakes: a transfer happens on a rising edge where the enable is
// high and the slave side is able (HOST_WR_READY for pushes, HOST_RD_VALID
// for pops); an enable without the matching ready/valid is ignored.
module fx2_slave_fifo #(
  parameter int DEPTH    = 16,
  parameter int PKT_SIZE = 8
) (
  input  logic       FX2_CLK,
  input  logic       FX2_RST_N,
  inout  wire  [7:0] FX2_FD,
  input  logic       FX2_SLRD,
  input  logic       FX2_SLWR,
  input  logic       FX2_PA_2,
  input  logic       FX2_PA_4,
  input  logic       FX2_PA_5,
  input  logic       FX2_PA_6,
  output logic [2:0] FX2_flags,
  output logic       FX2_PA_7,
  input  logic [7:0] HOST_WR_DATA,
  input  logic       HOST_WR_EN,
  output logic       HOST_WR_READY,
  output logic [7:0] HOST_RD_DATA,
  output logic       HOST_RD_VALID,
  input  logic       HOST_RD_EN,
  output logic       HOST_PKT,
  output logic       HOST_ZLP,
  output logic       RD_UNDERFLOW,
  output logic       WR_OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  // Active-high decode of the FX2 control pins
  logic       rd, wr, oe, pe;
  logic [1:0] adr;
  assign rd  = ~FX2_SLRD;
  assign wr  = ~FX2_SLWR;
  assign oe  = ~FX2_PA_2;
  assign pe  = ~FX2_PA_6;
  assign adr = {FX2_PA_5, FX2_PA_4};

  logic [7:0] mem2 [DEPTH];
  logic [7:0] mem4 [DEPTH];
  ptr_t wp2, rp2;        // FIFO2 write / read
  ptr_t wp4, cp4, rp4;   // FIFO4 write / commit / read

  ptr_t cnt2, cnt4;
  logic empty2, full2, full4;
  assign cnt2   = wp2 - rp2;
  assign cnt4   = wp4 - rp4;
  assign empty2 = (cnt2 == '0);
  assign full2  = (cnt2 == ptr_t'(DEPTH));
  assign full4  = (cnt4 == ptr_t'(DEPTH));

  logic push2, pop2, push4, pop4, rd_empty, wr_full;
  assign push2    = HOST_WR_EN && !full2;
  assign pop2     = rd && (adr == 2'b00) && !empty2;
  assign rd_empty = rd && (adr == 2'b00) && empty2;
  assign push4    = wr && (adr == 2'b10) && !full4;
  assign wr_full  = wr && (adr == 2'b10) && full4;
  assign pop4     = HOST_RD_EN && HOST_RD_VALID;

  // Commit logic looks at the write pointer as it will be after this edge,
  // so a byte pushed together with PKTEND belongs to the committed packet.
  ptr_t wp4_next, unc_next;
  logic pe_commit, auto_commit;
  assign wp4_next    = wp4 + {{AW{1'b0}}, push4};
  assign unc_next    = wp4_next - cp4;
  assign pe_commit   = pe && (adr == 2'b10);
  assign auto_commit = push4 && (unc_next == ptr_t'(PKT_SIZE));

  always_ff @(posedge FX2_CLK or negedge FX2_RST_N) begin
    if (!FX2_RST_N) begin
      wp2          <= '0;
      rp2          <= '0;
      wp4          <= '0;
      cp4          <= '0;
      rp4          <= '0;
      HOST_PKT     <= 1'b0;
      HOST_ZLP     <= 1'b0;
      RD_UNDERFLOW <= 1'b0;
      WR_OVERFLOW  <= 1'b0;
    end else begin
      if (push2) wp2 <= wp2 + 1'b1;
      if (pop2)  rp2 <= rp2 + 1'b1;
      if (pop4)  rp4 <= rp4 + 1'b1;
      wp4 <= wp4_next;
      if (pe_commit || auto_commit) cp4 <= wp4_next;
      // Auto-commit and PKTEND on one edge merge into a single HOST_PKT.
      HOST_PKT <= auto_commit || (pe_commit && (wp4_next != cp4));
      HOST_ZLP <= pe_commit && (wp4_next == cp4);
      if (rd_empty) RD_UNDERFLOW <= 1'b1;
      if (wr_full)  WR_OVERFLOW  <= 1'b1;
    end
  end

  // Storage needs no reset: every read is gated by the pointers.
  always_ff @(posedge FX2_CLK) begin
    if (push2) mem2[wp2[AW-1:0]] <= HOST_WR_DATA;
    if (push4) mem4[wp4[AW-1:0]] <= FX2_FD;
  end

  // FX2_FD: first-word fall-through view of FIFO2, 00 when empty
  logic       fd_drive;
  logic [7:0] fd_data;
  assign fd_drive = oe && (adr == 2'b00) && FX2_RST_N;
  assign fd_data  = empty2 ? 8'h00 : mem2[rp2[AW-1:0]];
  assign FX2_FD   = fd_drive ? fd_data : 8'hzz;

  assign FX2_flags     = {~full4, 1'b0, ~empty2};
  assign FX2_PA_7      = 1'b1;
  assign HOST_WR_READY = ~full2;
  assign HOST_RD_VALID = (rp4 != cp4);
  assign HOST_RD_DATA  = HOST_RD_VALID ? mem4[rp4[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_fx2_slave_fifo.sv
// tb_fx2_slave_fifo
//   Directed bench for fx2_slave_fifo (DEPTH 16, PKT_SIZE 8).
module tb_fx2_slave_fifo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  wire  [7:0] fd;
  logic [7:0] fd_drv;
  logic       fd_en;
  assign fd = fd_en ? fd_drv : 8'hzz;

  logic       slrd, slwr, sloe, pa4, pa5, pktend;
  logic [2:0] flags;
  logic       pa7;
  logic [7:0] host_wr_data;
  logic       host_wr_en, host_wr_ready;
  logic [7:0] host_rd_data;
  logic       host_rd_valid, host_rd_en;
  logic       host_pkt, host_zlp, rd_underflow, wr_overflow;

  fx2_slave_fifo #(.DEPTH(16), .PKT_SIZE(8)) dut (
    .FX2_CLK      (clk),
    .FX2_RST_N    (rst_n),
    .FX2_FD       (fd),
    .FX2_SLRD     (slrd),
    .FX2_SLWR     (slwr),
    .FX2_PA_2     (sloe),
    .FX2_PA_4     (pa4),
    .FX2_PA_5     (pa5),
    .FX2_PA_6     (pktend),
    .FX2_flags    (flags),
    .FX2_PA_7     (pa7),
    .HOST_WR_DATA (host_wr_data),
    .HOST_WR_EN   (host_wr_en),
    .HOST_WR_READY(host_wr_ready),
    .HOST_RD_DATA (host_rd_data),
    .HOST_RD_VALID(host_rd_valid),
    .HOST_RD_EN   (host_rd_en),
    .HOST_PKT     (host_pkt),
    .HOST_ZLP     (host_zlp),
    .RD_UNDERFLOW (rd_underflow),
    .WR_OVERFLOW  (wr_overflow)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];   // bytes expected back from FIFO4, in order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    slrd = 1'b1; slwr = 1'b1; sloe = 1'b1; pa4 = 1'b0; pa5 = 1'b0; pktend = 1'b1;
    fd_en = 1'b0; fd_drv = 8'h00;
    host_wr_en = 1'b0; host_wr_data = 8'h00; host_rd_en = 1'b0;
  endtask

  task automatic host_push(input logic [7:0] b);
    host_wr_data = b; host_wr_en = 1'b1;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic fpga_write(input logic [7:0] b, input logic with_pe);
    sloe = 1'b1; pa5 = 1'b1; pa4 = 1'b0;
    fd_en = 1'b1; fd_drv = b; slwr = 1'b0; pktend = ~with_pe;
    tick();
    slwr = 1'b1; pktend = 1'b1; fd_en = 1'b0;
  endtask

  task automatic fpga_pktend();
    pa5 = 1'b1; pa4 = 1'b0; pktend = 1'b0;
    tick();
    pktend = 1'b1;
  endtask

  task automatic host_pop(input string tag);
    logic [7:0] e;
    check({tag, "_valid"}, host_rd_valid, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, host_rd_data, e);
    end
    host_rd_en = 1'b1;
    tick();
    host_rd_en = 1'b0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    sloe = 1'b0;   // bus enable asserted during reset must not matter
    #12;
    check("rst_flags",    flags, 3'b100);
    check("rst_pa7",      pa7, 1'b1);
    check("rst_wr_ready", host_wr_ready, 1'b1);
    check("rst_rd_valid", host_rd_valid, 1'b0);
    check("rst_rd_data",  host_rd_data, 8'h00);
    check("rst_pkt",      host_pkt, 1'b0);
    check("rst_zlp",      host_zlp, 1'b0);
    check("rst_underflow", rd_underflow, 1'b0);
    check("rst_overflow", wr_overflow, 1'b0);
    sloe = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // FIFO2 read path: A5 then 3C, fall-through on FD
    host_push(8'hA5);
    check("f2_flag_after_push", flags[0], 1'b1);
    host_push(8'h3C);
    sloe = 1'b0; pa5 = 1'b0; pa4 = 1'b0;
    #1;
    check("f2_head_a5", fd, 8'hA5);
    slrd = 1'b0;
    tick();
    check("f2_head_3c", fd, 8'h3C);
    check("f2_flag_one_left", flags[0], 1'b1);
    tick();
    slrd = 1'b1;
    check("f2_flag_empty", flags[0], 1'b0);
    check("f2_fd_empty_00", fd, 8'h00);
    check("f2_no_underflow", rd_underflow, 1'b0);

    // simultaneous push and pop on FIFO2
    host_push(8'h11);
    host_wr_data = 8'h22; host_wr_en = 1'b1; slrd = 1'b0;
    tick();
    host_wr_en = 1'b0; slrd = 1'b1;
    check("f2_simul_head", fd, 8'h22);
    check("f2_simul_flag", flags[0], 1'b1);
    slrd = 1'b0;
    tick();
    slrd = 1'b1;
    check("f2_simul_drained", flags[0], 1'b0);

    // FIFO2 full: 16 pushes, 17th dropped, data drained through FD
    for (int i = 0; i < 16; i++) host_push(8'h20 + 8'(i));
    check("f2_full_ready", host_wr_ready, 1'b0);
    host_push(8'hEE);
    slrd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("f2_full_data", fd, 8'h20 + 8'(i));
      tick();
    end
    slrd = 1'b1;
    check("f2_full_drained", flags[0], 1'b0);
    check("f2_full_ready_back", host_wr_ready, 1'b1);
    sloe = 1'b1;

    // 3-byte packet with PKTEND
    for (int i = 1; i <= 3; i++) begin
      fpga_write(8'(i), 1'b0);
      exp_q.push_back(8'(i));
      check("p3_hidden", host_rd_valid, 1'b0);
      check("p3_no_pkt", host_pkt, 1'b0);
    end
    fpga_pktend();
    check("p3_valid", host_rd_valid, 1'b1);
    check("p3_pkt", host_pkt, 1'b1);
    check("p3_zlp", host_zlp, 1'b0);
    tick();
    check("p3_pkt_once", host_pkt, 1'b0);
    for (int i = 0; i < 3; i++) host_pop("p3_read");
    check("p3_drained", host_rd_valid, 1'b0);

    // zero-length packet
    fpga_pktend();
    check("zlp_zlp", host_zlp, 1'b1);
    check("zlp_pkt", host_pkt, 1'b0);
    tick();
    check("zlp_once", host_zlp, 1'b0);

    // 5th byte together with PKTEND
    for (int i = 0; i < 5; i++) begin
      fpga_write(8'h50 + 8'(i), i == 4);
      exp_q.push_back(8'h50 + 8'(i));
      check("p5_pkt", host_pkt, i == 4);
    end
    check("p5_zlp", host_zlp, 1'b0);
    tick();
    check("p5_pkt_once", host_pkt, 1'b0);
    for (int i = 0; i < 5; i++) host_pop("p5_read");
    check("p5_drained", host_rd_valid, 1'b0);

    // other addresses are ignored
    pa5 = 1'b0; pa4 = 1'b1; fd_en = 1'b1; fd_drv = 8'h99; slwr = 1'b0; pktend = 1'b0;
    tick();
    idle();
    check("ign_wr_valid", host_rd_valid, 1'b0);
    check("ign_pe_pkt", host_pkt, 1'b0);
    check("ign_pe_zlp", host_zlp, 1'b0);
    pa5 = 1'b1; pa4 = 1'b1; slrd = 1'b0;
    tick();
    idle();
    check("ign_rd_underflow", rd_underflow, 1'b0);

    // 16 writes: auto-commit after bytes 8 and 16, then overflow
    for (int i = 0; i < 16; i++) begin
      fpga_write(8'(i), 1'b0);
      exp_q.push_back(8'(i));
      check("auto_pkt", host_pkt, (i == 7) || (i == 15));
      if (i == 7) check("auto_valid8", host_rd_valid, 1'b1);
    end
    check("auto_full_flag", flags[2], 1'b0);
    check("auto_no_overflow", wr_overflow, 1'b0);
    fpga_write(8'hEE, 1'b0);
    check("auto_overflow", wr_overflow, 1'b1);
    check("auto_ovf_no_pkt", host_pkt, 1'b0);
    for (int i = 0; i < 16; i++) host_pop("auto_read");
    check("auto_drained", host_rd_valid, 1'b0);
    check("auto_not_full", flags[2], 1'b1);
    check("auto_overflow_sticky", wr_overflow, 1'b1);

    // underflow on empty FIFO2, read pointer must not move
    sloe = 1'b0; pa5 = 1'b0; pa4 = 1'b0; slrd = 1'b0;
    tick();
    slrd = 1'b1;
    check("uf_flag", rd_underflow, 1'b1);
    check("uf_empty", flags[0], 1'b0);
    host_push(8'h77);
    check("uf_ptr_fd", fd, 8'h77);
    check("uf_ptr_flag", flags[0], 1'b1);
    slrd = 1'b0;
    tick();
    slrd = 1'b1;
    check("uf_single_byte", flags[0], 1'b0);
    check("uf_sticky", rd_underflow, 1'b1);
    idle();
    rst_pulse();
    check("uf_rst_underflow", rd_underflow, 1'b0);
    check("uf_rst_overflow", wr_overflow, 1'b0);
    check("uf_rst_flags", flags, 3'b100);

    // reset mid-packet discards uncommitted bytes
    for (int i = 0; i < 3; i++) fpga_write(8'hC0 + 8'(i), 1'b0);
    rst_pulse();
    check("midrst_valid", host_rd_valid, 1'b0);
    check("midrst_pkt", host_pkt, 1'b0);
    tick();
    check("midrst_pkt_later", host_pkt, 1'b0);
    fpga_pktend();
    check("midrst_zlp", host_zlp, 1'b1);
    check("midrst_no_pkt", host_pkt, 1'b0);
    check("midrst_still_empty", host_rd_valid, 1'b0);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fx2_slave_fifo.md
FX2_SLAVE_FIFO -- requirements
Module: fx2_slave_fifo

Interface
REQ-001 Parameter DEPTH, default 16, entries per FIFO; power of two, at least 4.
REQ-002 Parameter PKT_SIZE, default 8, uncommitted FIFO4 byte count that triggers auto-commit; at most DEPTH.
REQ-003 FX2_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 FX2_RST_N  in  1  reset, asynchronous, active-low.
REQ-005 FX2_FD  inout  8  FPGA-side data bus.
REQ-006 FX2_SLRD  in  1  read strobe, active-low.
REQ-007 FX2_SLWR  in  1  write strobe, active-low.
REQ-008 FX2_PA_2  in  1  SLOE bus-drive enable, active-low.
REQ-009 FX2_PA_4 / FX2_PA_5  in  1 each  FIFOADR[0] / FIFOADR[1].
REQ-010 FX2_PA_6  in  1  PKTEND, active-low.
REQ-011 FX2_flags  out  3  bit 0 = FIFO2 not empty; bit 1 = FIFO3 not empty (tied 0); bit 2 = FIFO4 not full.
REQ-012 FX2_PA_7  out  1  FIFO5 not full (tied 1).
REQ-013 HOST_WR_DATA / HOST_WR_EN / HOST_WR_READY  in 8 / in 1 / out 1  host push port into FIFO2 (PC->FPGA).
REQ-014 HOST_RD_DATA / HOST_RD_VALID / HOST_RD_EN  out 8 / out 1 / in 1  host pop port from FIFO4 (FPGA->PC), committed bytes only.
REQ-015 HOST_PKT / HOST_ZLP  out  1 each  one-cycle pulses: packet committed / zero-length packet committed.
REQ-016 RD_UNDERFLOW / WR_OVERFLOW  out  1 each  sticky error flags.

Function
REQ-017 The slave-FIFO decode uses active-high internal equivalents rd = ~FX2_SLRD, wr = ~FX2_SLWR, oe = ~FX2_PA_2, pe = ~FX2_PA_6, adr = {FX2_PA_5, FX2_PA_4}.
REQ-018 FIFO2 and FIFO4 are each DEPTH x 8 circular buffers with pointers one bit wider than log2(DEPTH), wrapping modulo 2*DEPTH.
REQ-019 FX2_FD is driven with the FIFO2 head byte (first-word fall-through) when oe=1, adr=00 and reset is deasserted; otherwise it is Z.
REQ-020 When oe=1 and FIFO2 is empty, FX2_FD is driven with 8'h00.
REQ-021 FIFO2 pops one byte on an edge with rd=1, adr=00 and FIFO2 non-empty.
REQ-022 An edge with rd=1, adr=00 and FIFO2 empty causes no pointer change and sets RD_UNDERFLOW.
REQ-023 FIFO4 pushes FX2_FD on an edge with wr=1, adr=10 and FIFO4 not full.
REQ-024 An edge with wr=1, adr=10 and FIFO4 full drops the byte and sets WR_OVERFLOW.
REQ-025 rd or wr with adr=01 or adr=11 is ignored, with no flag effect.
REQ-026 FX2_flags[0] and FX2_flags[2] derive from registered pointers only, so they reflect a push or pop one cycle after the edge.
REQ-027 FIFO4 keeps a commit pointer; bytes between the commit pointer and the write pointer are uncommitted and invisible to the host.
REQ-028 An edge with pe=1 and adr=10 sets commit = write pointer, including any byte pushed on the same edge.
REQ-029 On a pe commit, HOST_PKT pulses if at least one byte was committed; otherwise HOST_ZLP pulses.
REQ-030 When the uncommitted count reaches PKT_SIZE after a push, commit is set to the write pointer and HOST_PKT pulses; pe on the same edge produces only one pulse.
REQ-031 pe with adr other than 10 is ignored.
REQ-032 HOST_RD_VALID = (FIFO4 read pointer != commit pointer), and HOST_RD_DATA shows the head byte.
REQ-033 FIFO4 pops on HOST_RD_EN && HOST_RD_VALID; HOST_RD_EN while not valid is ignored.
REQ-034 HOST_WR_READY = FIFO2 not full; FIFO2 pushes on HOST_WR_EN && HOST_WR_READY, and a write while not ready is dropped silently.
REQ-035 A simultaneous push and pop on the same FIFO in one cycle both take effect, and the count is unchanged.
REQ-036 RD_UNDERFLOW and WR_OVERFLOW stay set until reset.

Reset
REQ-037 While FX2_RST_N=0, all pointers are 0, FX2_FD is Z, and the outputs are: FX2_flags=3'b100, FX2_PA_7=1, HOST_WR_READY=1, HOST_RD_VALID=0, HOST_RD_DATA=0, HOST_PKT=0, HOST_ZLP=0, error flags 0.
REQ-038 Reset asserted mid-packet discards all FIFO contents, including uncommitted bytes, and no HOST_PKT pulse is generated.

Verification
REQ-039 Host pushes 8'hA5 then 8'h3C; SLOE=0, adr=00, SLRD low for 2 edges -> FD shows A5 then 3C; flags[0] falls 1 cycle after the second pop.
REQ-040 FPGA writes 3 bytes 01,02,03 at adr=10, then PKTEND -> HOST_RD_VALID stays 0 until the commit edge; HOST_PKT pulses once; host reads 01,02,03.
REQ-041 PKTEND with no pending bytes -> HOST_ZLP=1 for one cycle; HOST_PKT stays 0.
REQ-042 16 writes with no host reads (DEPTH 16, PKT_SIZE 8) -> auto-commits after bytes 8 and 16; flags[2]=0; a 17th write sets WR_OVERFLOW, and data 0..15 is intact.
REQ-043 SLRD low at adr=00 with FIFO2 empty -> RD_UNDERFLOW=1 and pointers unchanged; FX2_RST_N pulse -> RD_UNDERFLOW=0 and flags=3'b100.
REQ-044 SLWR and PKTEND on the same edge as the 5th byte -> 5-byte packet committed with a single HOST_PKT pulse.
